// File: rtl/noc_mem_endpoint.sv
// noc_mem_endpoint: memory-side endpoint between the NOC C2M output and M2C input.
// Requests are queued in a FIFO and each one is serviced as an atomic swap on a
// small internal memory: the new data is written and the old data is returned.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   en_C2M_OUT/Data_C2M_OUT/Addr_C2M_OUT   request in (no backpressure)
//   en_M2C_IN/Data_M2C_IN/AccessComplete_M2C_IN  response out (one-cycle pulse)
//   fifo_count                       request FIFO occupancy
//   overflow, bad_id                 sticky error flags
module noc_mem_endpoint #(
  parameter int unsigned RADIX          = 2,
  parameter int unsigned BIT_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned MEM_AW         = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned SERVICE_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en_C2M_OUT,
  input  logic [BIT_WIDTH-1:0]          Data_C2M_OUT,
  input  logic [ADDR_WIDTH-1:0]         Addr_C2M_OUT,
  output logic                          en_M2C_IN,
  output logic [BIT_WIDTH-1:0]          Data_M2C_IN,
  output logic [RADIX-1:0]              AccessComplete_M2C_IN,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          bad_id
);

  localparam int unsigned ID_W      = (RADIX > 1) ? $clog2(RADIX) : 1;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned SC_W      = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;
  localparam int unsigned MEM_WORDS = 1 << MEM_AW;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  // Only the id field and word index of a request are kept.
  logic [BIT_WIDTH-1:0]  r_fifo_data [FIFO_DEPTH];
  logic [ID_W-1:0]       r_fifo_id   [FIFO_DEPTH];
  logic [MEM_AW-1:0]     r_fifo_idx  [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;

  logic [BIT_WIDTH-1:0]  r_mem [MEM_WORDS];
  logic [BIT_WIDTH-1:0]  r_req_data;
  logic [ID_W-1:0]       r_req_id;
  logic [MEM_AW-1:0]     r_req_idx;
  logic [SC_W-1:0]       r_cnt;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_done;
  logic                  w_unused_addr;

  assign w_empty       = (fifo_count == '0);
  assign w_full        = (fifo_count == CNT_W'(FIFO_DEPTH));
  // Bits between the index and the id field carry no meaning here.
  assign w_unused_addr = ^Addr_C2M_OUT;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == '0) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = w_empty ? S_IDLE : S_BUSY;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM control outputs
  always_comb begin
    w_pop  = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE:  w_pop  = !w_empty;
      S_BUSY:  w_done = (r_cnt == '0);
      S_RESP:  w_pop  = !w_empty;
      default: w_pop  = 1'b0;
    endcase
    // A full FIFO still accepts when it is popped on the same edge.
    w_push = en_C2M_OUT && (!w_full || w_pop);
  end

  // FIFO storage (contents need no reset; occupancy is tracked separately)
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_fifo_data[r_wr_ptr] <= Data_C2M_OUT;
      r_fifo_id[r_wr_ptr]   <= Addr_C2M_OUT[ADDR_WIDTH-1 -: ID_W];
      r_fifo_idx[r_wr_ptr]  <= Addr_C2M_OUT[MEM_AW-1:0];
    end
  end

  // FIFO pointers/occupancy, request registers, memory and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr              <= '0;
      r_rd_ptr              <= '0;
      fifo_count            <= '0;
      overflow              <= 1'b0;
      bad_id                <= 1'b0;
      r_req_data            <= '0;
      r_req_id              <= '0;
      r_req_idx             <= '0;
      r_cnt                 <= '0;
      en_M2C_IN             <= 1'b0;
      Data_M2C_IN           <= '0;
      AccessComplete_M2C_IN <= '0;
      for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (en_C2M_OUT && !w_push) overflow <= 1'b1;

      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
        r_req_data <= r_fifo_data[r_rd_ptr];
        r_req_id   <= r_fifo_id[r_rd_ptr];
        r_req_idx  <= r_fifo_idx[r_rd_ptr];
        r_cnt      <= SC_W'(SERVICE_CYCLES - 1);
      end else if (r_state == S_BUSY && r_cnt != '0) begin
        r_cnt <= r_cnt - SC_W'(1);
      end

      case ({w_push, w_pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase

      // Response registers are live only during RESP; cleared otherwise.
      en_M2C_IN             <= 1'b0;
      Data_M2C_IN           <= '0;
      AccessComplete_M2C_IN <= '0;
      if (w_done) begin
        en_M2C_IN          <= 1'b1;
        Data_M2C_IN        <= r_mem[r_req_idx];
        r_mem[r_req_idx]   <= r_req_data;
        if (32'(r_req_id) < RADIX) AccessComplete_M2C_IN <= RADIX'(1) << r_req_id;
        else                       bad_id <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_noc_mem_endpoint.sv
// Bench for noc_mem_endpoint. Two instances share one stimulus stream: RADIX=2
// (the reference configuration) and RADIX=3, whose 2-bit id field can hold the
// out-of-range id 3. A transaction-level model predicts accept/drop and swap
// results; expected responses go into per-instance queues that a negedge
// monitor drains whenever a response is presented.
module tb_noc_mem_endpoint;

  localparam int SC    = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] din;
  logic [15:0] ain;

  logic        en2, ovf2, bad2;
  logic [31:0] data2;
  logic [1:0]  ac2;
  logic [2:0]  cnt2;
  logic        en3, ovf3, bad3;
  logic [31:0] data3;
  logic [2:0]  ac3;
  logic [2:0]  cnt3;

  always #5 clk = ~clk;

  noc_mem_endpoint #(.RADIX(2), .BIT_WIDTH(32), .ADDR_WIDTH(16), .MEM_AW(4),
                     .FIFO_DEPTH(DEPTH), .SERVICE_CYCLES(SC)) u_dut2 (
    .clk(clk), .rst(rst), .en_C2M_OUT(en), .Data_C2M_OUT(din), .Addr_C2M_OUT(ain),
    .en_M2C_IN(en2), .Data_M2C_IN(data2), .AccessComplete_M2C_IN(ac2),
    .fifo_count(cnt2), .overflow(ovf2), .bad_id(bad2));

  noc_mem_endpoint #(.RADIX(3), .BIT_WIDTH(32), .ADDR_WIDTH(16), .MEM_AW(4),
                     .FIFO_DEPTH(DEPTH), .SERVICE_CYCLES(SC)) u_dut3 (
    .clk(clk), .rst(rst), .en_C2M_OUT(en), .Data_C2M_OUT(din), .Addr_C2M_OUT(ain),
    .en_M2C_IN(en3), .Data_M2C_IN(data3), .AccessComplete_M2C_IN(ac3),
    .fifo_count(cnt3), .overflow(ovf3), .bad_id(bad3));

  typedef struct packed {
    logic [31:0] data;
    logic [15:0] addr;
  } req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  ac;
    logic        bad;
    int          due;
  } exp_t;

  req_t        mq   [2][$];
  exp_t        eq   [2][$];
  logic [31:0] mmem [2][16];
  logic        movf [2];
  logic        mbad [2];
  int          free_at [2];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_on = 1'b0;

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d actual=%0h expected=%0h", name, d, cyc, act, exp);
    end
  endtask

  // Reference model, one clock edge: the server takes the queue head once the
  // previous swap has been answered (SC busy edges + one response cycle).
  task automatic model_edge(input int d);
    req_t r;
    exp_t e;
    int   id, rad, idx;
    if (rst) begin
      mq[d].delete();
      eq[d].delete();
      for (int i = 0; i < 16; i++) mmem[d][i] = '0;
      movf[d]    = 1'b0;
      mbad[d]    = 1'b0;
      free_at[d] = 0;
      return;
    end
    if (mq[d].size() > 0 && cyc >= free_at[d]) begin
      r     = mq[d].pop_front();
      idx   = int'(r.addr[3:0]);
      id    = (d == 0) ? int'(r.addr[15]) : int'(r.addr[15:14]);
      rad   = (d == 0) ? 2 : 3;
      e.data = mmem[d][idx];
      mmem[d][idx] = r.data;
      e.ac  = (id < rad) ? 3'(1 << id) : 3'b000;
      e.bad = (id >= rad);
      e.due = cyc + SC;
      eq[d].push_back(e);
      free_at[d] = cyc + SC + 1;
    end
    if (en) begin
      if (mq[d].size() < DEPTH) mq[d].push_back('{data: din, addr: ain});
      else                      movf[d] = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) model_edge(d);
  end

  task automatic check_dut(input int d, input logic ren, input logic [31:0] rdata,
                           input logic [2:0] rac, input logic [2:0] rcnt,
                           input logic rovf, input logic rbad);
    exp_t e;
    if (ren) begin
      if (eq[d].size() == 0) begin
        chk("unexpected_resp", d, 64'(ren), 64'(0));
      end else begin
        e = eq[d].pop_front();
        chk("resp_cycle", d, 64'(cyc), 64'(e.due));
        chk("resp_data", d, 64'(rdata), 64'(e.data));
        chk("resp_access_complete", d, 64'(rac), 64'(e.ac));
        if (e.bad) mbad[d] = 1'b1;
      end
    end else begin
      chk("idle_outputs", d, {29'(0), rac, rdata}, 64'(0));
      if (eq[d].size() > 0 && eq[d][0].due <= cyc)
        chk("missing_resp", d, 64'(ren), 64'(1));
    end
    chk("fifo_count", d, 64'(rcnt), 64'(mq[d].size()));
    chk("overflow", d, 64'(rovf), 64'(movf[d]));
    chk("bad_id", d, 64'(rbad), 64'(mbad[d]));
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check_dut(0, en2, data2, {1'b0, ac2}, cnt2, ovf2, bad2);
      check_dut(1, en3, data3, ac3, cnt3, ovf3, bad3);
    end
  end

  task automatic send(input logic [31:0] d, input logic [15:0] a);
    en  = 1'b1;
    din = d;
    ain = a;
    @(negedge clk);
    en  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    din = '0;
    ain = '0;
    @(negedge clk);
    mon_on = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Single swap into zeroed memory, then the reverse swap and a re-read
    send(32'hA5A5A5A5, 16'h0003);
    idle(6);
    send(32'h12345678, 16'h8003);
    idle(6);
    send(32'h00000000, 16'h0003);
    idle(6);

    // Back-to-back burst longer than the FIFO can absorb
    for (int i = 0; i < 8; i++) send(32'hC0DE0000 + 32'(i), 16'(i % 3 + 1));
    idle(30);

    // Id field 3: out of range for the RADIX=3 instance
    send(32'hDEADBEEF, 16'hC005);
    idle(6);
    send(32'h0BADF00D, 16'h4005);
    idle(6);

    // Reset while busy with requests queued
    send(32'h11111111, 16'h0007);
    send(32'h22222222, 16'h0007);
    send(32'h33333333, 16'h0008);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);
    send(32'h44444444, 16'h0007);
    idle(6);

    // Index decode ignores middle address bits
    send(32'hF0F0F0F0, 16'h03FF);
    send(32'h0F0F0F0F, 16'h03F0);
    idle(10);

    // Randomised traffic with bursts and occasional resets
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 25));
      din = $urandom;
      ain = 16'($urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    en  = 1'b0;
    idle(40);

    for (int d = 0; d < 2; d++) begin
      chk("drained_responses", d, 64'(eq[d].size()), 64'(0));
      chk("drained_fifo", d, 64'(mq[d].size()), 64'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
